// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// Bit i of each 2-bit vector belongs to requester i.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic [1:0]        ReqValid;
  logic [1:0]        ReqReady;
  logic [DATA_W-1:0] ReqA0;
  logic [DATA_W-1:0] ReqB0;
  logic [DATA_W-1:0] ReqA1;
  logic [DATA_W-1:0] ReqB1;
  logic [CTRL_W-1:0] ReqCtrl0;
  logic [CTRL_W-1:0] ReqCtrl1;
  logic [1:0]        RespValid;
  logic [1:0]        RespReady;
  logic [DATA_W-1:0] RespResult;
  logic              RespZero;
  logic              RespIllegal;

  modport master (
    output ReqValid,
    output ReqA0,
    output ReqB0,
    output ReqA1,
    output ReqB1,
    output ReqCtrl0,
    output ReqCtrl1,
    output RespReady,
    input  ReqReady,
    input  RespValid,
    input  RespResult,
    input  RespZero,
    input  RespIllegal
  );

  modport slave (
    input  ReqValid,
    input  ReqA0,
    input  ReqB0,
    input  ReqA1,
    input  ReqB1,
    input  ReqCtrl0,
    input  ReqCtrl1,
    input  RespReady,
    output ReqReady,
    output RespValid,
    output RespResult,
    output RespZero,
    output RespIllegal
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one datapath ALU between two requesters.
// One operation in flight: IDLE grant -> EXEC settle -> RESP handshake.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  output logic [CTRL_W-1:0] AluCtrl,
  input  logic [DATA_W-1:0] AluResult,
  input  logic              AluZero,
  output logic              Busy,
  output logic [CNT_W-1:0]  OpCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_owner;
  logic              r_ptr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_res;
  logic              r_zero;
  logic              r_ill;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_gnt;
  logic              w_acc;
  logic              w_done;
  logic [1:0]        w_ready;
  logic [1:0]        w_rvalid;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_ill;

  function automatic logic f_illegal(input logic [CTRL_W-1:0] c);
    logic ill;
    unique case (c)
      CTRL_W'(0), CTRL_W'(1), CTRL_W'(2),
      CTRL_W'(3), CTRL_W'(6), CTRL_W'(7): ill = 1'b0;
      default:                            ill = 1'b1;
    endcase
    return ill;
  endfunction

  always_comb begin
    unique case (bus.ReqValid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      default: w_gnt = r_ptr;
    endcase
  end

  assign w_a    = w_gnt ? bus.ReqA1    : bus.ReqA0;
  assign w_b    = w_gnt ? bus.ReqB1    : bus.ReqB0;
  assign w_ctrl = w_gnt ? bus.ReqCtrl1 : bus.ReqCtrl0;
  assign w_ill  = f_illegal(r_ctrl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 2'b00;
    w_rvalid = 2'b00;
    w_acc    = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.ReqValid) begin
          w_ready[w_gnt] = 1'b1;
          w_acc          = 1'b1;
          w_next         = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        w_rvalid[r_owner] = 1'b1;
        if (bus.RespReady[r_owner]) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_owner <= w_gnt;
        r_a     <= w_a;
        r_b     <= w_b;
        r_ctrl  <= w_ctrl;
      end
      if (r_state == S_EXEC) begin
        r_res  <= AluResult;
        r_zero <= AluZero;
        r_ill  <= w_ill;
      end
      // pointer moves only on completion, so a grant alone never reorders
      if (w_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_ptr <= ~r_owner;
      end
    end
  end

  assign bus.ReqReady    = w_ready & {2{rst_n}};
  assign bus.RespValid   = w_rvalid;
  assign bus.RespResult  = r_res;
  assign bus.RespZero    = r_zero;
  assign bus.RespIllegal = r_ill;
  assign AluA            = r_a;
  assign AluB            = r_b;
  assign AluCtrl         = r_ctrl;
  assign Busy            = (r_state != S_IDLE);
  assign OpCount         = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic
// against a transaction-level model with a behavioural ALU.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] AluA;
  logic [DW-1:0] AluB;
  logic [CW-1:0] AluCtrl;
  logic [DW-1:0] AluResult;
  logic          AluZero;
  logic          Busy;
  logic [NW-1:0] OpCount;

  alu_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) bus();

  alu_arbiter #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluCtrl   (AluCtrl),
    .AluResult (AluResult),
    .AluZero   (AluZero),
    .Busy      (Busy),
    .OpCount   (OpCount)
  );

  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          m_cnt;
  logic        m_ptr;
  logic        o_own;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [3:0]  o_c;
  logic [3:0]  ops [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
  endfunction

  assign AluResult = ref_alu(AluA, AluB, AluCtrl);
  assign AluZero   = (AluResult == '0);

  a_hold0: assert property (@(posedge clk) disable iff (!rst_n)
    bus.ReqValid[0] && !bus.ReqReady[0] |=> bus.ReqValid[0] &&
    $stable(bus.ReqA0) && $stable(bus.ReqB0) && $stable(bus.ReqCtrl0));
  a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
    bus.ReqValid[1] && !bus.ReqReady[1] |=> bus.ReqValid[1] &&
    $stable(bus.ReqA1) && $stable(bus.ReqB1) && $stable(bus.ReqCtrl1));

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic present(input logic i, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    if (i) begin
      bus.ReqA1 = a; bus.ReqB1 = b; bus.ReqCtrl1 = c;
    end else begin
      bus.ReqA0 = a; bus.ReqB0 = b; bus.ReqCtrl0 = c;
    end
    bus.ReqValid[i] = 1'b1;
  endtask

  task automatic rand_present(input logic i);
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    a = $urandom;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    c = ($urandom_range(4) == 0) ? 4'($urandom) : ops[$urandom_range(5)];
    present(i, a, b, c);
  endtask

  task automatic reset_checks();
    check("rst_rdy", bus.ReqReady, 0);
    check("rst_rv", bus.RespValid, 0);
    check("rst_res", bus.RespResult, 0);
    check("rst_zero", bus.RespZero, 0);
    check("rst_ill", bus.RespIllegal, 0);
    check("rst_a", AluA, 0);
    check("rst_b", AluB, 0);
    check("rst_ctl", AluCtrl, 0);
    check("rst_cnt", OpCount, 0);
    check("rst_busy", Busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_checks();
    m_cnt = 0;
    m_ptr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic grant();
    logic e;
    e = (bus.ReqValid == 2'b11) ? m_ptr : bus.ReqValid[1];
    check("idle_busy", Busy, 0);
    check("grant", bus.ReqReady, 2'b01 << e);
    o_own = e;
    o_a = e ? bus.ReqA1 : bus.ReqA0;
    o_b = e ? bus.ReqB1 : bus.ReqB0;
    o_c = e ? bus.ReqCtrl1 : bus.ReqCtrl0;
    @(posedge clk);
    @(negedge clk);
    bus.ReqValid[o_own] = 1'b0;
    #1;
    check("exec_busy", Busy, 1);
    check("exec_rdy", bus.ReqReady, 0);
    check("exec_rv", bus.RespValid, 0);
    check("alu_a", AluA, o_a);
    check("alu_b", AluB, o_b);
    check("alu_ctl", AluCtrl, o_c);
  endtask

  task automatic check_resp();
    logic [31:0] r;
    r = ref_alu(o_a, o_b, o_c);
    check("resp_rv", bus.RespValid, 2'b01 << o_own);
    check("result", bus.RespResult, r);
    check("zero", bus.RespZero, r == 0);
    check("illegal", bus.RespIllegal, !legal(o_c));
    check("resp_rdy", bus.ReqReady, 0);
    check("resp_busy", Busy, 1);
  endtask

  task automatic to_resp();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_resp();
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      bus.RespReady[!o_own] = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      #1;
      check_resp();
    end
    bus.RespReady = 2'b00;
  endtask

  task automatic accept();
    bus.RespReady[o_own] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.RespReady = 2'b00;
    m_cnt = (m_cnt + 1) % (1 << NW);
    m_ptr = !o_own;
    #1;
    check("opcount", OpCount, m_cnt);
    check("done_rv", bus.RespValid, 0);
    check("done_busy", Busy, 0);
  endtask

  task automatic txn(input int delay);
    grant();
    to_resp();
    hold(delay);
    accept();
  endtask

  task automatic rand_txn();
    for (int i = 0; i < 2; i++)
      if (!bus.ReqValid[i] && $urandom_range(3) != 0) rand_present(1'(i));
    if (bus.ReqValid == 2'b00) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("idle_rdy", bus.ReqReady, 0);
      check("idle_busy", Busy, 0);
      rand_present(1'($urandom));
    end
    #1;
    txn($urandom_range(3));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ReqValid = 2'b00;
    bus.RespReady = 2'b00;
    bus.ReqA0 = '0; bus.ReqB0 = '0; bus.ReqCtrl0 = '0;
    bus.ReqA1 = '0; bus.ReqB1 = '0; bus.ReqCtrl1 = '0;
    #2;
    do_reset();

    present(1'b0, 32'd5, 32'd7, 4'd2);
    #1;
    grant();
    to_resp();
    check("add_res", bus.RespResult, 32'd12);
    accept();
    check("add_cnt", OpCount, 1);

    do_reset();
    present(1'b0, 32'd9, 32'd9, 4'd6);
    present(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7);
    #1;
    grant();
    to_resp();
    check("sub_zero", bus.RespZero, 1);
    accept();
    grant();
    to_resp();
    check("slt_res", bus.RespResult, 1);
    accept();
    rand_present(1'b0);
    rand_present(1'b1);
    #1;
    check("ptr_back0", bus.ReqReady, 2'b01);
    txn(0);

    grant();
    present(1'b0, 32'd1, 32'd2, 4'd0);
    #1;
    to_resp();
    hold(10);
    accept();
    check("bp_next", bus.ReqReady, 2'b01);
    txn(1);

    present(1'b1, 32'd3, 32'd4, 4'hF);
    #1;
    grant();
    to_resp();
    check("ill_flag", bus.RespIllegal, 1);
    check("ill_res", bus.RespResult, 0);
    check("ill_zero", bus.RespZero, 1);
    accept();

    rand_present(1'b0);
    rand_present(1'b1);
    #1;
    grant();
    to_resp();
    do_reset();
    check("no_resp", bus.RespValid, 0);
    txn(0);
    check("post_rst_cnt", OpCount, 1);

    do_reset();
    repeat (16) rand_txn();
    check("wrap", OpCount, 0);

    repeat (80) rand_txn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit datapath ALU between two requesters: the main execute stage (port 0) and an auxiliary unit such as address-gen or a debug/test engine (port 1).
- Round-robin arbitration, registered operands and registered result; drives the ALU's A, B and ALUControl and captures its ALUResult and Zero.
- One transaction in flight; valid/ready handshake on both request and response sides.

Parameters:
- DATA_W, 32, operand/result width (must match ALU).
- CTRL_W, 4, ALU opcode width.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  2  bit i: requester i presents an operation.
- ReqReady  out  2  bit i: requester i's operation accepted this cycle.
- ReqA0, ReqB0 / ReqA1, ReqB1  in  DATA_W each  operands of requester 0 / 1.
- ReqCtrl0 / ReqCtrl1  in  CTRL_W each  opcode of requester 0 / 1.
- RespValid  out  2  bit i: result for requester i available.
- RespReady  in  2  bit i: requester i consumes result.
- RespResult  out  DATA_W  latched ALU result (shared by both requesters).
- RespZero  out  1  latched ALU Zero flag.
- RespIllegal  out  1  opcode was not AND/OR/ADD/XOR/SUB/SLT (0000, 0001, 0010, 0011, 0110, 0111).
- AluA, AluB  out  DATA_W  to ALU operand inputs (registered).
- AluCtrl  out  CTRL_W  to ALU opcode input (registered).
- AluResult  in  DATA_W  from ALU.
- AluZero  in  1  from ALU.
- Busy  out  1  state != IDLE.
- OpCount  out  CNT_W  completed (response-accepted) operations.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, ReqReady=0, RespValid=0, RespResult=0, RespZero=0, RespIllegal=0, AluA/AluB/AluCtrl=0, OpCount=0, priority pointer=0, Busy=0.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE grant (combinational): only one valid -> that one; both valid -> requester at priority pointer. ReqReady[g]=1 only in IDLE for granted g; ReqReady=0 in all other states.
- Handshake at edge with ReqValid[g]&ReqReady[g]: latch g's operands/opcode into AluA/AluB/AluCtrl, store owner=g, go EXEC.
- EXEC (exactly 1 cycle): ALU settles on registered inputs; at end edge latch AluResult->RespResult, AluZero->RespZero, illegal-opcode decode->RespIllegal; go RESP.
- RESP: RespValid[owner]=1, other bit 0; RespResult/RespZero/RespIllegal held stable until accepted. Edge with RespReady[owner]=1: go IDLE, OpCount+1 (wraps at 2^CNT_W-1 -> 0), pointer = ~owner.
- RespReady of non-owner is ignored.
- Latency: accept at edge N -> RespValid high after edge N+1; minimum 3 cycles per operation.
- Illegal opcode: still sent to ALU (ALU yields 0, Zero=1); RespIllegal=1, operation completes and counts normally.
- Requester rule: ReqValid, once high, holds with stable payload until ReqReady; ReqValid must not depend combinationally on ReqReady. Verification asserts both.
- Pointer changes only on response acceptance, never on mere grant; starvation bound: a waiting requester is served within one other transaction.
- Reset asserted mid-EXEC/RESP: transaction discarded, no response, OpCount not incremented.
- AluA/AluB/AluCtrl hold last values in IDLE (no toggling without a new grant).

Test Plan:
- Reset then req0 ADD A=5,B=7: ReqReady[0] at cycle 0, RespValid[0] at cycle 2 with Result=12, Zero=0; RespReady[0]=1 -> IDLE, OpCount=1.
- Both valid, pointer=0: req0 SUB 9-9 served first (Result=0, Zero=1), then req1 SLT A=0xFFFFFFFF,B=1 -> Result=1; after that both valid again -> req0 granted (pointer=0).
- Response backpressure: RespReady[1] held 0 for 10 cycles -> RespValid[1], Result stable, ReqReady=0 throughout, req0 waiting is not accepted; release -> req0 granted next cycle.
- Opcode 1111 from req1 with A=3,B=4: Result=0, Zero=1, RespIllegal=1, OpCount increments.
- rst_n pulsed low during RESP: all outputs 0 immediately (async), no response delivered, OpCount=0; after release, pending req1 accepted normally.
- OpCount wrap: with CNT_W=4, 16 completed ops -> OpCount returns to 0.
